// File: rtl/phase_bank_mv.sv
// Multi-voice phase accumulator bank: one shared adder sweeps VOICES voices per sample_tick.
// Voice k is emitted (registered) k+1 cycles after the tick; ticks arriving while busy are dropped and flagged in overrun.
module phase_bank_mv #(
    parameter int                 VOICES      = 8,
    parameter int                 PHASE_W     = 16,
    parameter logic [PHASE_W-1:0] DEFAULT_INC = 16'h2F0,
    localparam int                VW          = $clog2(VOICES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sample_tick,
    input  logic               cfg_valid,
    input  logic [VW-1:0]      cfg_voice,
    input  logic               cfg_gate,
    input  logic [PHASE_W-1:0] cfg_inc,
    input  logic               ovr_clr,
    output logic               out_valid,
    output logic [VW-1:0]      out_voice,
    output logic [PHASE_W-1:0] out_phase,
    output logic               out_active,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t             state_q, state_d;
    logic [VW-1:0]      idx_q, idx_d;
    logic               gate_q  [VOICES];
    logic               gate_d  [VOICES];
    logic [PHASE_W-1:0] inc_q   [VOICES];
    logic [PHASE_W-1:0] inc_d   [VOICES];
    logic [PHASE_W-1:0] phase_q [VOICES];
    logic [PHASE_W-1:0] phase_d [VOICES];

    logic               out_valid_q, out_valid_d;
    logic [VW-1:0]      out_voice_q, out_voice_d;
    logic [PHASE_W-1:0] out_phase_q, out_phase_d;
    logic               out_active_q, out_active_d;
    logic               busy_q, busy_d;
    logic               ovr_q, ovr_d;

    logic               accept;
    logic               drop;
    logic               proc_en;
    logic [VW-1:0]      proc_idx;
    logic               cfg_hit;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        gate_d       = gate_q;
        inc_d        = inc_q;
        phase_d      = phase_q;
        out_voice_d  = out_voice_q;
        out_phase_d  = out_phase_q;
        out_active_d = out_active_q;

        // busy_q stays high while the last voice is on the outputs, so it is the drop window
        accept   = sample_tick && !busy_q;
        drop     = sample_tick && busy_q;
        proc_en  = accept || (state_q == SWEEP);
        proc_idx = (state_q == SWEEP) ? idx_q : '0;

        if (state_q == SWEEP) begin
            idx_d = idx_q + VW'(1);
            if (idx_q == VW'(VOICES - 1)) begin
                state_d = IDLE;
                idx_d   = '0;
            end
        end else if (accept) begin
            state_d = SWEEP;
            idx_d   = VW'(1);
        end

        out_valid_d = proc_en;
        busy_d      = proc_en;
        if (proc_en) begin
            out_voice_d       = proc_idx;
            out_phase_d       = phase_q[proc_idx];
            out_active_d      = gate_q[proc_idx];
            phase_d[proc_idx] = gate_q[proc_idx] ? phase_q[proc_idx] + inc_q[proc_idx] : '0;
        end

        // Config overrides the sweep update; a retune keeps the stored (pre-edge) phase
        cfg_hit = cfg_valid && (int'(cfg_voice) < VOICES);
        if (cfg_hit) begin
            inc_d[cfg_voice]   = cfg_inc;
            gate_d[cfg_voice]  = cfg_gate;
            phase_d[cfg_voice] = (cfg_gate && gate_q[cfg_voice]) ? phase_q[cfg_voice] : '0;
        end

        if (drop) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            out_valid_q  <= 1'b0;
            out_voice_q  <= '0;
            out_phase_q  <= '0;
            out_active_q <= 1'b0;
            busy_q       <= 1'b0;
            ovr_q        <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                gate_q[i]  <= 1'b0;
                inc_q[i]   <= DEFAULT_INC;
                phase_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            out_valid_q  <= out_valid_d;
            out_voice_q  <= out_voice_d;
            out_phase_q  <= out_phase_d;
            out_active_q <= out_active_d;
            busy_q       <= busy_d;
            ovr_q        <= ovr_d;
            gate_q       <= gate_d;
            inc_q        <= inc_d;
            phase_q      <= phase_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_voice  = out_voice_q;
    assign out_phase  = out_phase_q;
    assign out_active = out_active_q;
    assign busy       = busy_q;
    assign overrun    = ovr_q;

endmodule
